// File: rtl/interconnect_arbiter.sv
// ============================================================================
// interconnect_arbiter: round-robin owner arbiter for a shared interconnect bus
// with turnaround gaps, slot pre-emption and registered outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interconnect_arbiter #(
    parameter int         N_REQ       = 4,
    parameter int         SLOT_CYCLES = 1024,
    parameter int         TURN_CYCLES = 2,
    parameter logic [2:0] IDLE_MODE   = 3'b111
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       mode_out,
    output logic             bus_oe,
    output logic             preempt
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] C_SLOT_MAX  = SLOT_W'(SLOT_CYCLES);
    localparam logic [TURN_W-1:0] C_TURN_LAST = TURN_W'(TURN_CYCLES - 1);
    localparam logic [2:0]        C_LAST_RST  = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TURN_IN  = 2'd1,
        S_OWN      = 2'd2,
        S_TURN_OUT = 2'd3
    } state_t;

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [2:0]        r_mode;
    logic              r_bus_oe;
    logic              r_preempt;
    logic [2:0]        r_last;
    logic [TURN_W-1:0] r_turn_cnt;
    logic [SLOT_W-1:0] r_slot_cnt;

    state_t            w_state;
    logic [N_REQ-1:0]  w_grant;
    logic [2:0]        w_mode;
    logic              w_bus_oe;
    logic              w_preempt;
    logic [2:0]        w_last;
    logic [TURN_W-1:0] w_turn_cnt;
    logic [SLOT_W-1:0] w_slot_cnt;

    logic [7:0]        w_req_ext;
    logic              w_any_req;
    logic              w_owner_req;
    logic              w_others;
    logic [2:0]        w_win_idx;
    logic [N_REQ-1:0]  w_win_grant;
    logic [SLOT_W-1:0] w_slot_inc;

    // The owner index doubles as last_owner: it is updated on TURN_IN entry.
    assign w_req_ext   = 8'(req);
    assign w_any_req   = |req;
    assign w_owner_req = w_req_ext[r_last];
    assign w_others    = |(req & ~r_grant);
    assign w_slot_inc  = (r_slot_cnt == C_SLOT_MAX) ? C_SLOT_MAX
                                                    : r_slot_cnt + SLOT_W'(1);
    assign w_win_grant = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;

    always_comb begin : arb
        logic [3:0] cand;
        logic       found;
        cand      = 4'd0;
        found     = 1'b0;
        w_win_idx = r_last;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, r_last} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!found && w_req_ext[cand[2:0]]) begin
                found     = 1'b1;
                w_win_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_grant    = r_grant;
        w_mode     = r_mode;
        w_bus_oe   = r_bus_oe;
        w_preempt  = 1'b0;
        w_last     = r_last;
        w_turn_cnt = r_turn_cnt;
        w_slot_cnt = r_slot_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state    = S_TURN_IN;
                    w_grant    = w_win_grant;
                    w_mode     = w_win_idx;
                    w_last     = w_win_idx;
                    w_bus_oe   = 1'b0;
                    w_turn_cnt = '0;
                end
            end
            S_TURN_IN: begin
                if (!w_owner_req) begin
                    w_state    = S_TURN_OUT;
                    w_grant    = '0;
                    w_mode     = IDLE_MODE;
                    w_turn_cnt = '0;
                end else if (r_turn_cnt == C_TURN_LAST) begin
                    w_state    = S_OWN;
                    w_bus_oe   = 1'b1;
                    w_slot_cnt = '0;
                end else begin
                    w_turn_cnt = r_turn_cnt + TURN_W'(1);
                end
            end
            S_OWN: begin
                // Release takes priority over pre-emption.
                if (!w_owner_req || (w_slot_inc == C_SLOT_MAX && w_others)) begin
                    w_state    = S_TURN_OUT;
                    w_grant    = '0;
                    w_mode     = IDLE_MODE;
                    w_bus_oe   = 1'b0;
                    w_preempt  = w_owner_req;
                    w_turn_cnt = '0;
                    w_slot_cnt = '0;
                end else begin
                    w_slot_cnt = w_slot_inc;
                end
            end
            S_TURN_OUT: begin
                if (r_turn_cnt == C_TURN_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_turn_cnt = r_turn_cnt + TURN_W'(1);
                end
            end
            default: begin
                w_state  = S_IDLE;
                w_grant  = '0;
                w_mode   = IDLE_MODE;
                w_bus_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_mode     <= IDLE_MODE;
            r_bus_oe   <= 1'b0;
            r_preempt  <= 1'b0;
            r_last     <= C_LAST_RST;
            r_turn_cnt <= '0;
            r_slot_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_grant    <= w_grant;
            r_mode     <= w_mode;
            r_bus_oe   <= w_bus_oe;
            r_preempt  <= w_preempt;
            r_last     <= w_last;
            r_turn_cnt <= w_turn_cnt;
            r_slot_cnt <= w_slot_cnt;
        end
    end

    assign grant    = r_grant;
    assign mode_out = r_mode;
    assign bus_oe   = r_bus_oe;
    assign preempt  = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_interconnect_arbiter.sv
// ============================================================================
// tb_interconnect_arbiter: directed and random checks against a phase/timer model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interconnect_arbiter;

    localparam int         N      = 4;
    localparam int         SLOT   = 8;
    localparam int         TURN   = 2;
    localparam logic [2:0] IDLE_M = 3'b111;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] grant;
    logic [2:0]   mode_out;
    logic         bus_oe;
    logic         preempt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interconnect_arbiter #(
        .N_REQ      (N),
        .SLOT_CYCLES(SLOT),
        .TURN_CYCLES(TURN),
        .IDLE_MODE  (IDLE_M)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .mode_out(mode_out),
        .bus_oe  (bus_oe),
        .preempt (preempt)
    );

    // Model: phase 0 idle, 1 turn-in, 2 owning, 3 turn-out; countdown timers.
    int m_phase;
    int m_owner;
    int m_last;
    int m_left;
    int m_held;
    bit m_pre;

    function automatic int pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = -1;
        m_last  = N - 1;
        m_left  = 0;
        m_held  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_tick(input logic [N-1:0] r);
        m_pre = 1'b0;
        case (m_phase)
            0: if (r != '0) begin
                m_owner = pick(m_last, r);
                m_last  = m_owner;
                m_phase = 1;
                m_left  = TURN;
            end
            1: if (!r[m_owner]) begin
                m_phase = 3; m_left = TURN; m_owner = -1;
            end else begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_held = 0; end
            end
            2: begin
                m_held++;
                if (!r[m_owner]) begin
                    m_phase = 3; m_left = TURN; m_owner = -1;
                end else if (m_held >= SLOT && (r & ~(N'(1) << m_owner)) != '0) begin
                    m_phase = 3; m_left = TURN; m_owner = -1; m_pre = 1'b1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    function automatic logic [N-1:0] exp_grant();
        return (m_phase == 1 || m_phase == 2) ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic logic [2:0] exp_mode();
        return (m_phase == 1 || m_phase == 2) ? 3'(m_owner) : IDLE_M;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("grant",   32'(grant),    32'(exp_grant()));
        chk("mode",    32'(mode_out), 32'(exp_mode()));
        chk("bus_oe",  32'(bus_oe),   32'(m_phase == 2));
        chk("preempt", 32'(preempt),  32'(m_pre));
        chk("onehot",  32'($onehot0(grant)), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_tick(req);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

    initial begin
        int waited;
        model_reset();

        // Reset held with all requests active.
        req = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        chk("rst_mode", 32'(mode_out), 32'(3'b111));
        reset_n = 1'b1;

        // Single requester, held indefinitely.
        req = 4'b0001;
        step();
        chk("single_grant", 32'(grant), 32'(4'b0001));
        chk("single_mode", 32'(mode_out), 32'(3'b000));
        step();
        chk("single_turnin_oe", 32'(bus_oe), 32'd0);
        step();
        chk("single_own_oe", 32'(bus_oe), 32'd1);
        repeat (20) step();

        // Expired slot: a new competitor pre-empts immediately.
        req = 4'b0101;
        repeat (40) step();

        // Owner releases mid-slot while requester 3 waits.
        req = 4'b1100;
        waited = 0;
        while (!(bus_oe && grant == 4'b0100) && waited < 60) begin step(); waited++; end
        chk("wait_owner2", 32'(bus_oe && grant == 4'b0100), 32'd1);
        step();
        req = 4'b1000;
        repeat (12) step();

        // Wrap-around after reset.
        async_reset();
        req = 4'b1001;
        step();
        chk("wrap_first", 32'(grant), 32'(4'b0001));
        repeat (30) step();

        // Reset while owning, then last_owner restarts at N-1.
        waited = 0;
        while (!bus_oe && waited < 60) begin step(); waited++; end
        chk("wait_own", 32'(bus_oe), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midown_grant", 32'(grant), 32'd0);
        chk("midown_oe", 32'(bus_oe), 32'd0);
        chk("midown_mode", 32'(mode_out), 32'(3'b111));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b0010;
        step();
        chk("post_rst_grant", 32'(grant), 32'(4'b0010));

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interconnect_arbiter.md
INTERCONNECT_ARBITER -- requirements
Module: interconnect_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the interconnect bus (range 2..7).
REQ-002 Parameter SLOT_CYCLES, default 1024, OWN-state cycles after which a contended owner is pre-empted (≥1).
REQ-003 Parameter TURN_CYCLES, default 2, bus-released turnaround cycles on every ownership change (≥1).
REQ-004 Parameter IDLE_MODE, default 3'b111, mode code driven when no requester owns the bus.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req  input  N_REQ  level request per requester; bit i high = requester i wants the bus.
REQ-008 grant  output  N_REQ  one-hot owner indication; zero when no owner.
REQ-009 mode_out  output  3  owner index (zero-extended) while grant≠0, else IDLE_MODE; drives the interconnect mode field.
REQ-010 bus_oe  output  1  owner may drive the shared bus; high only in OWN.
REQ-011 preempt  output  1  one-cycle pulse on the cycle OWN exits due to slot expiry.

Function
REQ-012 FSM states: IDLE, TURN_IN, OWN, TURN_OUT; all outputs registered.
REQ-013 IDLE: req==0 -> stay; else next cycle TURN_IN with grant/mode_out set to the arbitration winner, bus_oe=0.
REQ-014 Arbitration: round-robin; search starts at (last_owner+1) mod N_REQ, wrapping; first set req bit wins.
REQ-015 last_owner updates on entry to TURN_IN; reset value N_REQ-1, so req[0] has highest priority after reset.
REQ-016 TURN_IN lasts exactly TURN_CYCLES cycles, then OWN with bus_oe=1; grant and mode_out unchanged.
REQ-017 Owner's req bit low on any TURN_IN cycle -> next cycle TURN_OUT; bus_oe never asserts.
REQ-018 OWN: slot counter starts at 0 on entry and increments each cycle, saturating at SLOT_CYCLES.
REQ-019 OWN exit when owner's req low (release) or counter==SLOT_CYCLES and any other req bit high (pre-empt); release wins if both hold.
REQ-020 Expired slot with no other requester: owner keeps bus indefinitely; pre-empt on the first cycle another req rises.
REQ-021 OWN exit -> TURN_OUT next cycle: grant=0, bus_oe=0, mode_out=IDLE_MODE.
REQ-022 TURN_OUT lasts exactly TURN_CYCLES cycles, then IDLE; arbitration in IDLE that cycle per REQ-013 (no extra idle cycle required beyond the IDLE cycle itself).
REQ-023 Requests from non-owners during TURN_IN/OWN/TURN_OUT are not latched; only current req level is evaluated in IDLE.
REQ-024 bus_oe and a new grant never assert in the same cycle; bus_oe low for ≥TURN_CYCLES+1 cycles between owners.
REQ-025 grant always one-hot or zero; mode_out always consistent with grant in the same cycle.

Reset
REQ-026 reset_n low asynchronously forces IDLE, grant=0, bus_oe=0, preempt=0, mode_out=IDLE_MODE, slot counter=0, last_owner=N_REQ-1, from any state including mid-OWN.
REQ-027 First arbitration after reset_n rises occurs on the first rising clk edge with req≠0.

Verification (N_REQ=4, SLOT_CYCLES=8, TURN_CYCLES=2)
REQ-028 Reset: reset_n=0 with req=4'b1111 -> grant=0, bus_oe=0, mode_out=3'b111, preempt=0 throughout.
REQ-029 Single request: req=4'b0001 held from cycle 0 -> grant=0001, mode_out=000 at cycle 1; bus_oe=1 from cycle 3; holds indefinitely, preempt never pulses.
REQ-030 Contention/pre-empt: req=4'b0101 held -> requester 0 owns; bus_oe high 8 cycles, preempt pulses, 2 TURN_OUT cycles at mode 111, then grant=0100, mode_out=010.
REQ-031 Release: owner 2 drops req mid-OWN -> next cycle grant=0, bus_oe=0; after 2 cycles IDLE; pending req=4'b1000 -> grant=1000.
REQ-032 Wrap-around: last_owner=3, req=4'b1001 -> grant=0001; then last_owner=0, req=4'b1001 -> grant=1000.
REQ-033 Reset mid-OWN: reset_n low during bus_oe=1 -> outputs to reset values without waiting for clk; after release, req=4'b0010 -> grant=0010 (last_owner reset).
